// File: rtl/viterbi_ber_checker_if.sv
// Bit-stream monitor bus: tx/rx bit streams and clear in, lock status and statistics out.
interface viterbi_ber_checker_if #(
    parameter int unsigned MAX_LAT = 64,
    parameter int unsigned CW      = 32
);
    localparam int unsigned LW = $clog2(MAX_LAT + 1);

    logic          tx_valid_i;
    logic          tx_bit_i;
    logic          rx_valid_i;
    logic          rx_bit_i;
    logic          clear_i;
    logic          locked_o;
    logic [LW-1:0] latency_o;
    logic [CW-1:0] bit_ct_o;
    logic [CW-1:0] err_ct_o;
    logic [15:0]   burst_max_o;
    logic          sat_o;

    modport master (
        output tx_valid_i, tx_bit_i, rx_valid_i, rx_bit_i, clear_i,
        input  locked_o, latency_o, bit_ct_o, err_ct_o, burst_max_o, sat_o
    );

    modport slave (
        input  tx_valid_i, tx_bit_i, rx_valid_i, rx_bit_i, clear_i,
        output locked_o, latency_o, bit_ct_o, err_ct_o, burst_max_o, sat_o
    );
endinterface

// File: rtl/viterbi_ber_checker.sv
// Decoder-output BER monitor: searches the decoder lag against a tx bit history,
// locks, then accumulates bit/error/burst statistics with loss-of-lock windows.
module viterbi_ber_checker #(
    parameter int unsigned MAX_LAT   = 64,
    parameter int unsigned LOCK_RUN  = 32,
    parameter int unsigned WIN       = 64,
    parameter int unsigned LOSS_ERRS = 8,
    parameter int unsigned CW        = 32
) (
    input  logic clk,
    input  logic rst,
    viterbi_ber_checker_if.slave bus
);
    localparam int unsigned LW = $clog2(MAX_LAT + 1);
    localparam int unsigned FW = $clog2(MAX_LAT + 2);
    localparam int unsigned RW = $clog2(LOCK_RUN + 1);
    localparam int unsigned WW = $clog2(WIN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(MAX_LAT + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [MAX_LAT:0] hist_q;
    logic [FW-1:0]   fill_q;
    logic [LW-1:0]   lag_q;
    logic [LW-1:0]   latency_q;
    logic [RW-1:0]   run_q;
    logic [WW-1:0]   win_bits_q;
    logic [WW-1:0]   win_errs_q;
    logic [CW-1:0]   bit_ct_q;
    logic [CW-1:0]   err_ct_q;
    logic [15:0]     cur_burst_q;
    logic [15:0]     burst_max_q;
    logic            sat_q;

    logic            cmp;
    logic            mism;
    logic [RW-1:0]   run_inc;
    logic [WW-1:0]   win_bits_inc;
    logic [WW-1:0]   win_errs_nx;
    logic            do_lock;
    logic            win_end;
    logic            do_loss;
    logic            count;
    logic [15:0]     burst_inc;

    // Compare only once the history holds a bit at the current lag.
    always_comb begin
        cmp          = bus.rx_valid_i && (fill_q > FW'(lag_q));
        mism         = bus.rx_bit_i != hist_q[lag_q];
        run_inc      = run_q + 1'b1;
        win_bits_inc = win_bits_q + 1'b1;
        win_errs_nx  = win_errs_q + WW'(mism);
        burst_inc    = (&cur_burst_q) ? cur_burst_q : cur_burst_q + 16'd1;
        do_lock      = (state_q == SEARCH) && cmp && !mism && (run_inc == RW'(LOCK_RUN));
        win_end      = (state_q == LOCKED) && cmp && (win_bits_inc == WW'(WIN));
        do_loss      = win_end && (win_errs_nx >= WW'(LOSS_ERRS));
        count        = (state_q == LOCKED) && cmp && !bus.clear_i;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH:  if (do_lock) state_d = LOCKED;
            LOCKED:  if (do_loss) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q      <= '0;
            fill_q      <= '0;
            lag_q       <= '0;
            latency_q   <= '0;
            run_q       <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            bit_ct_q    <= '0;
            err_ct_q    <= '0;
            cur_burst_q <= '0;
            burst_max_q <= '0;
            sat_q       <= 1'b0;
        end else begin
            if (bus.tx_valid_i) begin
                hist_q <= {hist_q[MAX_LAT-1:0], bus.tx_bit_i};
                if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
            end

            if ((state_q == SEARCH) && cmp) begin
                if (mism) begin
                    run_q <= '0;
                    lag_q <= (lag_q == LW'(MAX_LAT)) ? '0 : lag_q + 1'b1;
                end else if (do_lock) begin
                    run_q      <= '0;
                    latency_q  <= lag_q;
                    win_bits_q <= '0;
                    win_errs_q <= '0;
                end else begin
                    run_q <= run_inc;
                end
            end

            if ((state_q == LOCKED) && cmp) begin
                if (win_end) begin
                    win_bits_q <= '0;
                    win_errs_q <= '0;
                    if (do_loss) begin
                        lag_q <= '0;
                        run_q <= '0;
                    end
                end else begin
                    win_bits_q <= win_bits_inc;
                    win_errs_q <= win_errs_nx;
                end
            end

            // Clear outranks a same-cycle compare: that bit never reaches the stats.
            if (bus.clear_i) begin
                bit_ct_q    <= '0;
                err_ct_q    <= '0;
                cur_burst_q <= '0;
                burst_max_q <= '0;
                sat_q       <= 1'b0;
            end else if (count) begin
                if (&bit_ct_q) sat_q <= 1'b1;
                else           bit_ct_q <= bit_ct_q + 1'b1;
                if (mism) begin
                    if (&err_ct_q) sat_q <= 1'b1;
                    else           err_ct_q <= err_ct_q + 1'b1;
                    if (&cur_burst_q) sat_q <= 1'b1;
                    cur_burst_q <= burst_inc;
                    if (burst_inc > burst_max_q) burst_max_q <= burst_inc;
                end else begin
                    cur_burst_q <= '0;
                end
            end
        end
    end

    assign bus.locked_o    = (state_q == LOCKED);
    assign bus.latency_o   = latency_q;
    assign bus.bit_ct_o    = bit_ct_q;
    assign bus.err_ct_o    = err_ct_q;
    assign bus.burst_max_o = burst_max_q;
    assign bus.sat_o       = sat_q;
endmodule
